// File: rtl/data_cache_l1_pkg.sv
// rtl/data_cache_l1_pkg.sv - shared constants, state enum and wsize helpers for the L1 data cache
// Purpose: line geometry, controller state encoding and wsize decoding shared by
//          data_cache_l1 and dcache_byte_merge.
// Ports:   none (package).
package data_cache_l1_pkg;

  localparam int LINE_W     = 256;
  localparam int OFF_W      = 5;
  localparam int LINE_BYTES = LINE_W / 8;

  // wsize encoding: 0 is a full word, 1..3 are that many bytes.
  localparam logic [1:0] WSIZE_4B = 2'd0;
  localparam logic [1:0] WSIZE_1B = 2'd1;
  localparam logic [1:0] WSIZE_2B = 2'd2;
  localparam logic [1:0] WSIZE_3B = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL,
    ST_SCAN,
    ST_FWB
  } state_t;

  // Byte-lane mask of a write relative to its start byte.
  function automatic logic [3:0] wsize_mask(input logic [1:0] wsize);
    case (wsize)
      WSIZE_1B: wsize_mask = 4'b0001;
      WSIZE_2B: wsize_mask = 4'b0011;
      WSIZE_3B: wsize_mask = 4'b0111;
      WSIZE_4B: wsize_mask = 4'b1111;
      default:  wsize_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_cache_l1_byte_merge.sv
// rtl/data_cache_l1_byte_merge.sv - positions a store word inside a cache line with byte enables
// Purpose: combinational placement of wdata/wsize at a line offset.
// Ports:   i_wdata   store data (low wsize bytes used)
//          i_wsize   byte count, 0 = 4 bytes
//          i_offset  byte offset within the 32-byte line
//          o_line    store data shifted to its byte lanes
//          o_byte_en one bit per line byte that the store writes
module dcache_byte_merge
  import data_cache_l1_pkg::*;
(
  input  logic [31:0]           i_wdata,
  input  logic [1:0]            i_wsize,
  input  logic [OFF_W-1:0]      i_offset,
  output logic [LINE_W-1:0]     o_line,
  output logic [LINE_BYTES-1:0] o_byte_en
);

  assign o_line    = {{(LINE_W-32){1'b0}}, i_wdata} << {i_offset, 3'b000};
  assign o_byte_en = {{(LINE_BYTES-4){1'b0}}, wsize_mask(i_wsize)} << i_offset;

endmodule

// File: rtl/data_cache_l1.sv
// rtl/data_cache_l1.sv - direct-mapped write-back write-allocate L1 data cache
// Purpose: services MEM word reads/writes from a LINES-entry array of 256-bit lines,
//          refilling/evicting whole lines over the block port, plus a flush sweep.
// Ports:   CLK, RESET (async active-low)
//          addr/rd/wr/wdata/wsize/flush  MEM request;  rdata/valid  MEM response
//          mem_addr/blk_rd/blk_wr/blk_wdata  block request
//          blk_rdata/blk_rd_valid/blk_wr_valid  block response
module data_cache_l1
  import data_cache_l1_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        wsize,
  input  logic              flush,
  output logic [31:0]       rdata,
  output logic              valid,
  output logic [31:0]       mem_addr,
  output logic              blk_rd,
  output logic              blk_wr,
  output logic [LINE_W-1:0] blk_wdata,
  input  logic [LINE_W-1:0] blk_rdata,
  input  logic              blk_rd_valid,
  input  logic              blk_wr_valid
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];
  logic [IDX_W-1:0]  r_cnt;
  logic              r_flush_done;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [LINE_W-1:0]     w_line;
  logic                  w_hit;
  logic                  w_wr_hit;
  logic                  w_scan_dirty;
  logic                  w_cnt_last;
  logic [LINE_W-1:0]     w_st_line;
  logic [LINE_BYTES-1:0] w_st_be;
  logic [LINE_W-1:0]     w_merged;

  assign w_idx        = addr[OFF_W +: IDX_W];
  assign w_tag        = addr[31 -: TAG_W];
  assign w_line       = r_data[w_idx];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr_hit     = (r_state == ST_IDLE) && !flush && wr && w_hit;
  assign w_scan_dirty = r_valid[r_cnt] && r_dirty[r_cnt];
  assign w_cnt_last   = (r_cnt == LAST_IDX);

  dcache_byte_merge u_merge (
    .i_wdata   (wdata),
    .i_wsize   (wsize),
    .i_offset  (addr[OFF_W-1:0]),
    .o_line    (w_st_line),
    .o_byte_en (w_st_be)
  );

  always_comb begin
    w_merged = w_line;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (w_st_be[b]) w_merged[8*b +: 8] = w_st_line[8*b +: 8];
    end
  end

  always_comb begin
    w_next    = r_state;
    valid     = 1'b0;
    rdata     = '0;
    blk_rd    = 1'b0;
    blk_wr    = 1'b0;
    mem_addr  = '0;
    blk_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          // A completed sweep keeps reporting done until flush drops.
          valid = r_flush_done;
          if (!r_flush_done) w_next = ST_SCAN;
        end else if (rd || wr) begin
          if (w_hit) begin
            valid = 1'b1;
            if (rd) rdata = w_line[{addr[4:2], 5'b00000} +: 32];
          end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
            w_next = ST_WB;
          end else begin
            w_next = ST_FILL;
          end
        end else begin
          valid = 1'b1;
        end
      end
      ST_WB: begin
        blk_wr    = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx, 5'b00000};
        blk_wdata = w_line;
        if (blk_wr_valid) w_next = ST_FILL;
      end
      ST_FILL: begin
        blk_rd   = 1'b1;
        mem_addr = {addr[31:OFF_W], 5'b00000};
        if (blk_rd_valid) w_next = ST_IDLE;
      end
      ST_SCAN: begin
        if (w_scan_dirty)    w_next = ST_FWB;
        else if (w_cnt_last) w_next = ST_IDLE;
      end
      ST_FWB: begin
        blk_wr    = 1'b1;
        mem_addr  = {r_tag[r_cnt], r_cnt, 5'b00000};
        blk_wdata = r_data[r_cnt];
        if (blk_wr_valid) w_next = ST_SCAN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= ST_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_cnt        <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!flush) r_flush_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
          if (flush && !r_flush_done) r_cnt <= '0;
        end
        ST_WB: begin
          if (blk_wr_valid) r_dirty[w_idx] <= 1'b0;
        end
        ST_FILL: begin
          if (blk_rd_valid) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (!w_scan_dirty) begin
            r_valid[r_cnt] <= 1'b0;
            if (w_cnt_last) begin
              r_flush_done <= 1'b1;
              r_cnt        <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_FWB: begin
          if (blk_wr_valid) begin
            r_valid[r_cnt] <= 1'b0;
            r_dirty[r_cnt] <= 1'b0;
            // The last line is not advanced: SCAN re-sees it invalid and exits.
            if (!w_cnt_last) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx] <= w_merged;
    if (r_state == ST_FILL && blk_rd_valid) begin
      r_data[w_idx] <= blk_rdata;
      r_tag[w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_data_cache_l1.sv
// tb/tb_data_cache_l1.sv - self-checking bench for data_cache_l1
module tb_data_cache_l1;
  import data_cache_l1_pkg::*;

  localparam int LINES = 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [31:0]       addr;
  logic              rd;
  logic              wr;
  logic [31:0]       wdata;
  logic [1:0]        wsize;
  logic              flush;
  logic [31:0]       rdata;
  logic              valid;
  logic [31:0]       mem_addr;
  logic              blk_rd;
  logic              blk_wr;
  logic [LINE_W-1:0] blk_wdata;
  logic [LINE_W-1:0] blk_rdata;
  logic              blk_rd_valid;
  logic              blk_wr_valid;

  data_cache_l1 #(.LINES(LINES)) dut (
    .CLK(CLK), .RESET(RESET), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .wsize(wsize), .flush(flush), .rdata(rdata), .valid(valid), .mem_addr(mem_addr),
    .blk_rd(blk_rd), .blk_wr(blk_wr), .blk_wdata(blk_wdata), .blk_rdata(blk_rdata),
    .blk_rd_valid(blk_rd_valid), .blk_wr_valid(blk_wr_valid)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: cache keyed by line address, backing memory by line address.
  bit           mv    [LINES];
  bit           md    [LINES];
  logic [26:0]  mla   [LINES];
  logic [255:0] mdata [LINES];
  logic [255:0] mem   [logic [26:0]];

  logic [31:0]  exp_wb_a [$];
  logic [255:0] exp_wb_d [$];
  logic [31:0]  exp_rd_a [$];

  int svc_dly;
  bit svc_pend;
  int wb_acks;

  function automatic logic [255:0] mem_line(input logic [26:0] la);
    logic [255:0] v;
    if (!mem.exists(la)) begin
      for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
      mem[la] = v;
    end
    return mem[la];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  // Acts as the memory for one cycle: random ack latency, checks each accepted block request.
  task automatic service();
    logic [31:0]  ea;
    logic [255:0] ed;
    check("rd_wr_exclusive", blk_rd & blk_wr, 1'b0);
    if (blk_rd || blk_wr) begin
      if (!svc_pend) begin
        svc_pend = 1'b1;
        svc_dly  = $urandom_range(0, 2);
      end
      if (svc_dly == 0) begin
        svc_pend = 1'b0;
        if (blk_wr) begin
          wb_acks++;
          check("wb_expected", exp_wb_a.size() > 0, 1'b1);
          if (exp_wb_a.size() > 0) begin
            ea = exp_wb_a.pop_front();
            ed = exp_wb_d.pop_front();
            check("wb_addr", mem_addr, ea);
            check("wb_data", blk_wdata, ed);
            mem[ea[31:5]] = ed;
          end
          blk_wr_valid = 1'b1;
        end else begin
          check("rd_after_wb", exp_wb_a.size(), 0);
          check("rd_expected", exp_rd_a.size() > 0, 1'b1);
          if (exp_rd_a.size() > 0) begin
            ea = exp_rd_a.pop_front();
            check("rd_addr", mem_addr, ea);
          end
          blk_rdata    = mem_line(mem_addr[31:5]);
          blk_rd_valid = 1'b1;
        end
      end else begin
        svc_dly--;
      end
    end
  endtask

  task automatic run_until_valid(input int budget, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    svc_pend = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      #1;
      if (valid) begin
        done = 1'b1;
      end else begin
        service();
        @(negedge CLK);
        blk_rd_valid = 1'b0;
        blk_wr_valid = 1'b0;
        stalls++;
      end
    end
    check("valid_in_budget", done, 1'b1);
  endtask

  task automatic access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, output logic [31:0] got, output int stalls);
    logic [26:0] la;
    int idx;
    int n;
    bit hit;
    la  = a[31:5];
    idx = int'(la % LINES);
    hit = mv[idx] && (mla[idx] == la);
    if (!hit) begin
      if (mv[idx] && md[idx]) begin
        exp_wb_a.push_back({mla[idx], 5'b00000});
        exp_wb_d.push_back(mdata[idx]);
      end
      exp_rd_a.push_back({la, 5'b00000});
    end
    @(negedge CLK);
    rd    = !is_wr;
    wr    = is_wr;
    addr  = a;
    wdata = d;
    wsize = sz;
    run_until_valid(200, stalls);
    got = rdata;
    check("wb_left", exp_wb_a.size(), 0);
    check("rd_left", exp_rd_a.size(), 0);
    exp_wb_a.delete();
    exp_wb_d.delete();
    exp_rd_a.delete();
    if (hit) check("hit_stall", stalls, 0);
    else begin
      mv[idx]    = 1'b1;
      md[idx]    = 1'b0;
      mla[idx]   = la;
      mdata[idx] = mem_line(la);
    end
    if (is_wr) begin
      n = (sz == 2'd0) ? 4 : int'(sz);
      for (int k = 0; k < n; k++) mdata[idx][8*(int'(a[4:0]) + k) +: 8] = d[8*k +: 8];
      md[idx] = 1'b1;
    end else begin
      check("rdata", got, mdata[idx][32*int'(a[4:2]) +: 32]);
    end
  endtask

  task automatic do_flush(output int stalls);
    for (int i = 0; i < LINES; i++) begin
      if (mv[i] && md[i]) begin
        exp_wb_a.push_back({mla[i], 5'b00000});
        exp_wb_d.push_back(mdata[i]);
      end
    end
    wb_acks = 0;
    @(negedge CLK);
    rd    = 1'b0;
    wr    = 1'b0;
    flush = 1'b1;
    run_until_valid(400, stalls);
    check("flush_wb_left", exp_wb_a.size(), 0);
    check("flush_min_steps", stalls >= LINES, 1'b1);
    exp_wb_a.delete();
    exp_wb_d.delete();
    model_clear();
    @(negedge CLK);
    #1;
    check("flush_hold_valid", valid, 1'b1);
    check("flush_hold_no_wr", blk_wr, 1'b0);
    @(negedge CLK);
    flush = 1'b0;
  endtask

  logic [31:0] got;
  logic [31:0] a;
  int st, t, ix, w, n, off;
  bit seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; wsize = '0; flush = 1'b0;
    blk_rdata = '0; blk_rd_valid = 1'b0; blk_wr_valid = 1'b0;
    model_clear();
    @(negedge CLK);
    #1;
    check("rst_valid", valid, 1'b1);
    check("rst_blk_rd", blk_rd, 1'b0);
    check("rst_blk_wr", blk_wr, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_blk_wdata", blk_wdata, 256'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    mem[27'h80] = {224'h0, 32'hDEADBEEF};
    access(1'b0, 32'h1000, 32'h0, 2'd0, got, st);
    check("cold_rdata", got, 32'hDEADBEEF);
    access(1'b0, 32'h1000, 32'h0, 2'd0, got, st);
    check("repeat_rdata", got, 32'hDEADBEEF);
    access(1'b1, 32'h1004, 32'h11223344, 2'd0, got, st);
    access(1'b0, 32'h1004, 32'h0, 2'd0, got, st);
    check("word_rdata", got, 32'h11223344);
    check("word_stall", st, 0);
    access(1'b1, 32'h1007, 32'h55AA66AB, 2'd1, got, st);
    access(1'b0, 32'h1004, 32'h0, 2'd0, got, st);
    check("byte_rdata", got, 32'hAB223344);

    // Stray acknowledges while idle must be ignored.
    @(negedge CLK);
    rd = 1'b0; wr = 1'b0;
    blk_rdata = {8{$urandom}}; blk_rd_valid = 1'b1; blk_wr_valid = 1'b1;
    #1;
    check("stray_ack_valid", valid, 1'b1);
    @(negedge CLK);
    blk_rd_valid = 1'b0; blk_wr_valid = 1'b0;
    #1;
    check("stray_ack_idle", {blk_rd, blk_wr}, 2'b00);

    // Conflicting line evicts the dirty 0x1000 line first.
    access(1'b0, 32'h1000 + 32 * LINES, 32'h0, 2'd0, got, st);
    access(1'b1, 32'h1020, 32'hCAFEF00D, 2'd0, got, st);
    access(1'b1, 32'h1042, 32'h00009876, 2'd2, got, st);
    do_flush(st);
    check("flush_wb_count", wb_acks, 2);
    access(1'b0, 32'h1000, 32'h0, 2'd0, got, st);
    check("post_flush_miss", st > 0, 1'b1);

    // Reset in the middle of a refill.
    @(negedge CLK);
    rd = 1'b1; wr = 1'b0; addr = 32'h2040;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (blk_rd) seen = 1'b1;
      else @(negedge CLK);
    end
    check("rst_blk_rd_seen", seen, 1'b1);
    RESET = 1'b0;
    #1;
    check("rst_blk_rd_drop", blk_rd, 1'b0);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    rd = 1'b0;
    model_clear();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    access(1'b0, 32'h2040, 32'h0, 2'd0, got, st);

    for (int i = 0; i < 80; i++) begin
      t  = $urandom_range(0, 3);
      ix = $urandom_range(0, LINES - 1);
      w  = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        n   = $urandom_range(1, 4);
        off = $urandom_range(0, 4 - n);
        a   = 32'((t << 16) | (ix << 5) | (w << 2) | off);
        access(1'b1, a, $urandom, (n == 4) ? 2'd0 : 2'(n), got, st);
      end else begin
        a = 32'((t << 16) | (ix << 5) | (w << 2));
        access(1'b0, a, 32'h0, 2'd0, got, st);
      end
    end
    do_flush(st);
    for (int i = 0; i < 10; i++) begin
      a = 32'(($urandom_range(0, 3) << 16) | ($urandom_range(0, LINES - 1) << 5));
      access(1'b0, a, 32'h0, 2'd0, got, st);
    end

    @(negedge CLK);
    rd = 1'b0; wr = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_cache_l1.md
# data_cache_L1

Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and the data-memory block port. It consumes MEM's word-level requests (address, read/write, write data and size) and returns read data plus a `valid` stall signal. It moves whole 256-bit lines to and from memory over the `dBlkRead`/`dBlkWrite` handshake. It also performs the full write-back-and-invalidate sweep required before SYS.

## Interface
- `LINES`, 64: number of cache lines; power of two, at least 2. Index is log2(LINES) bits; tag is 27-log2(LINES) bits.
- `CLK` input 1: the only clock; all state changes on the rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `addr` input 32: byte address from MEM; bits [4:0] give the line offset.
- `rd` input 1: read request.
- `wr` input 1: write request; `rd` and `wr` are never both high.
- `wdata` input 32: write data; the low `wsize` bytes are used.
- `wsize` input 2: bytes to write; 1/2/3 mean that many bytes, 0 means 4 bytes.
- `flush` input 1: level request to write back all dirty lines and invalidate the cache.
- `rdata` output 32: the word at `addr & ~3`, little-endian lanes.
- `valid` output 1: high means the current request (or flush) completes this cycle.
- `mem_addr` output 32: line-aligned block address, bits [4:0] = 0.
- `blk_rd` output 1: block read request.
- `blk_wr` output 1: block write request.
- `blk_wdata` output 256: line being written back.
- `blk_rdata` input 256: refill data.
- `blk_rd_valid` input 1: one-cycle acknowledge that `blk_rdata` is valid.
- `blk_wr_valid` input 1: one-cycle acknowledge that the block write is accepted.

## Operation
- Per line, the cache stores a valid bit, a dirty bit, a tag and 256 bits of data. Byte b of the line is bits [8b+7:8b].
- States and transitions:
  - IDLE:
    - No request: `valid`=1.
    - Hit: `valid`=1 combinationally. For a read, `rdata` is driven from the array. For a write, the bytes `addr`..`addr`+n-1 take `wdata[8n-1:0]` at the edge, and dirty is set.
    - Miss on a valid, dirty victim: go to WB.
    - Other miss: go to FILL.
    - `flush` with the flush-done flag clear: go to SCAN with the index counter at 0.
  - WB: `blk_wr`=1, `mem_addr`={victim tag, index, 5'b0}, `blk_wdata`=victim line. On `blk_wr_valid`, clear dirty and go to FILL.
  - FILL: `blk_rd`=1, `mem_addr`={`addr`[31:5], 5'b0}. On `blk_rd_valid`, write the line, set valid, clear dirty, write the tag and return to IDLE. The access then hits the following cycle.
  - SCAN: for a line that is valid and dirty, go to FWB. Otherwise invalidate the line and increment the counter. After the last index, set the flush-done flag, return to IDLE and assert `valid`=1.
  - FWB: same handshake as WB for the scanned line. On acknowledge, invalidate the line, increment the counter and return to SCAN.
- The flush-done flag clears when `flush` drops. While `flush` stays high after completion, `valid`=1 and no new sweep starts.
- Writes never cross a 4-byte boundary; MEM guarantees this and the cache does not check it.
- `flush` takes priority over `rd`/`wr` in IDLE.

## Timing
- Reset, asynchronous: state=IDLE, all valid and dirty bits 0, counter 0, flush-done flag 0, `blk_rd`=0, `blk_wr`=0, `mem_addr`=0, `blk_wdata`=0. `rdata`=0 while no hit. `valid`=1 when no request is pending.
- Hit latency is 0 cycles (combinational). A clean miss costs at least 2 cycles (FILL plus the hit cycle). A dirty miss adds the WB cycles.
- `blk_rd` and `blk_wr` are never high together. Each holds steady with constant `mem_addr` until its acknowledge, then drops the next cycle.
- An acknowledge arriving while no request is outstanding is ignored.
- `valid`=0 in WB, FILL, SCAN and FWB; MEM holds its request stable during those states.
- Reset mid-refill or mid-writeback abandons the transfer; the line stays invalid.
- Counter wrap: SCAN exits when the counter equals LINES-1 and that line has been handled.

## Structure
- Shared package holds: line width (256), offset bits (5), the state enum (IDLE, WB, FILL, SCAN, FWB) and the `wsize` encoding constants.
- One natural sub-module, `dcache_byte_merge`: combinational merge of `wdata`/`wsize`/offset into a 256-bit line with a 32-bit byte enable.

## Test plan
- Cold read of 0x1000: `blk_rd` goes high with `mem_addr`=0x1000. Return a line with word 0 = 0xDEADBEEF and ack → `rdata`=0xDEADBEEF and `valid`=1 on the next cycle. A repeat read hits with no `blk_rd`.
- Write 0x11223344 size 0 to 0x1004 (hit), then read 0x1004 → 0x11223344 with 0 cycles of stall.
- Write size 1, `wdata`=0xAB, to 0x1007 over the word 0x11223344 → read of 0x1004 gives 0xAB223344.
- With 0x1000 dirty, read 0x1000+32·LINES → `blk_wr` with `mem_addr`=0x1000 and the dirty data. After `blk_wr_valid`, `blk_rd` for the new address follows.
- Two dirty lines, then raise `flush` → exactly two `blk_wr` with the correct addresses. `valid`=1 after LINES scan steps, and a following read misses.
- Assert `RESET` low while `blk_rd` is high → `blk_rd` drops immediately. After release, a read of the same address issues a fresh `blk_rd`.
